fifo_dest: RTL
==============

Name: fifo_dest

Overview:
- Per-destination buffer FIFO directly downstream of the destination demux.
- One instance per output (d0, d1): push driven by push_d0/push_d1, data by data_d0/data_d1.
- Buffers words until the destination-side consumer pops them.
- Exports full/empty and programmable almost-full/almost-empty flags; upstream flow control gates the demux's valid on almost_full.

Parameters:
- DATA_SIZE, 6, width of each stored word (matches demux data width).
- ADDR_SIZE, 2, address bits; depth = 2**ADDR_SIZE (default 4 entries).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- push  input  1  write request (from demux push_dX).
- data_in  input  DATA_SIZE  write data (from demux data_dX).
- pop  input  1  read request from consumer.
- af_thresh  input  ADDR_SIZE+1  almost-full threshold (occupancy).
- ae_thresh  input  ADDR_SIZE+1  almost-empty threshold (occupancy).
- data_out  output  DATA_SIZE  registered read data.
- valid_out  output  1  data_out holds a word popped on the previous edge.
- full  output  1  occupancy == depth.
- empty  output  1  occupancy == 0.
- almost_full  output  1  occupancy >= af_thresh.
- almost_empty  output  1  occupancy <= ae_thresh.
- fifo_error  output  1  push while full or pop while empty.

Behaviour:
- Storage:
  - Array of 2**ADDR_SIZE words.
  - wr_ptr, rd_ptr ADDR_SIZE bits, wrap modulo depth.
  - count ADDR_SIZE+1 bits, range 0..depth.
- Reset (async, any time, including mid-transfer):
  - wr_ptr = rd_ptr = count = 0.
  - data_out = 0, valid_out = 0, fifo_error = 0.
  - Memory contents need not be cleared.
  - Flags follow from count = 0: empty = 1, full = 0, almost_empty = 1 if ae_thresh >= 0 (always), almost_full = 1 only if af_thresh == 0.
  - After reset deasserts, the first edge is a normal cycle.
- Push accepted when push && (!full || pop_accepted):
  - mem[wr_ptr] <= data_in, wr_ptr increments.
- Pop accepted when pop && !empty:
  - data_out <= mem[rd_ptr], valid_out <= 1, rd_ptr increments.
  - Read latency 1 cycle.
- Without an accepted pop: valid_out <= 0; data_out holds its last value.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push & pop:
  - Full: both accepted, count stays at depth, no error.
  - Empty: pop rejected (no read-through); push accepted; count becomes 1; valid_out = 0; error raised for the pop.
  - Otherwise: both accepted.
- Rejected operations:
  - push while full (without accepted pop) is dropped; ptrs and count unchanged.
  - pop while empty returns nothing.
  - Either raises fifo_error per Optional Feature.
- Flags:
  - full, empty, almost_full, almost_empty are combinational from registered count and the threshold inputs (no extra latency).
  - Thresholds may change any cycle; flags track immediately.
- Wrap-around: pointers roll from depth-1 to 0 with no bubble; data order strictly FIFO across the wrap.

Optional Feature:
- Macro: FIFO_ERR_STICKY_EN.
- Defined: fifo_error sets on the edge following any rejected push/pop and stays 1 until reset.
- Undefined: fifo_error is a registered one-cycle pulse, 1 only in the cycle after each rejected operation, otherwise 0.

Test Plan:
- Reset then idle -> empty = 1, full = 0, valid_out = 0, data_out = 0, fifo_error = 0.
- Push 0x11, 0x22, 0x33, 0x04 on consecutive edges (af_thresh = 3) -> full = 1 after 4th edge, almost_full = 1 from 3rd edge; then pop x4 -> data_out 0x11, 0x22, 0x33, 0x04 each one cycle after pop, valid_out = 1 each, empty = 1 at end.
- Full FIFO, push 0x3F with no pop -> word dropped, fifo_error = 1 next cycle (pulse or sticky per macro); subsequent 4 pops return original data only.
- Full FIFO, push 0x2A with pop same cycle -> count stays 4, no error; 0x2A emerges as 4th pop after the three remaining originals.
- Empty FIFO, push 0x15 and pop same cycle -> valid_out = 0, count = 1, fifo_error asserted; next pop -> data_out = 0x15.
- 10 push/pop interleaved cycles crossing pointer wrap, then assert reset mid-stream -> all outputs return to reset values asynchronously; post-reset push/pop of 0x09 works normally.

Source files
------------

// File: rtl/fifo_dest_if.sv
// Handshake/data bundle between the destination demux (master) and one fifo_dest buffer (slave).
interface fifo_dest_if #(
   parameter int DATA_SIZE = 6,
   parameter int ADDR_SIZE = 2
);
   logic                  push;
   logic [DATA_SIZE-1:0]  data_in;
   logic                  pop;
   logic [ADDR_SIZE:0]    af_thresh;
   logic [ADDR_SIZE:0]    ae_thresh;
   logic [DATA_SIZE-1:0]  data_out;
   logic                  valid_out;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic                  fifo_error;

   modport master (
      output push, data_in, pop, af_thresh, ae_thresh,
      input  data_out, valid_out, full, empty, almost_full, almost_empty, fifo_error
   );

   modport slave (
      input  push, data_in, pop, af_thresh, ae_thresh,
      output data_out, valid_out, full, empty, almost_full, almost_empty, fifo_error
   );
endinterface

// File: rtl/fifo_dest.sv
// Per-destination FIFO behind the demux; registered read port, occupancy flags and error report.
// FIFO_ERR_STICKY_EN: when defined, fifo_error latches until reset instead of pulsing one cycle.
module fifo_dest #(
   parameter int DATA_SIZE = 6,
   parameter int ADDR_SIZE = 2
) (
   input  logic        clk,
   input  logic        reset,
   fifo_dest_if.slave  bus
);
   localparam int                 DEPTH     = 1 << ADDR_SIZE;
   localparam logic [ADDR_SIZE:0] DEPTH_CNT = (ADDR_SIZE+1)'(DEPTH);

   logic [DATA_SIZE-1:0] mem_q [DEPTH];

   logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_SIZE:0]   count_q, count_d;
   logic [DATA_SIZE-1:0] data_out_q, data_out_d;
   logic                 valid_out_q, valid_out_d;
   logic                 fifo_error_q, fifo_error_d;

   logic full, empty;
   logic pop_ok, push_ok, rejected;

   assign full  = (count_q == DEPTH_CNT);
   assign empty = (count_q == '0);

   // A pop frees a slot in the same edge, so a push into a full FIFO is legal when paired with one.
   assign pop_ok   = bus.pop && !empty;
   assign push_ok  = bus.push && (!full || pop_ok);
   assign rejected = (bus.push && !push_ok) || (bus.pop && empty);

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      data_out_d   = data_out_q;
      valid_out_d  = 1'b0;

      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end

      if (pop_ok) begin
         rd_ptr_d    = rd_ptr_q + 1'b1;
         data_out_d  = mem_q[rd_ptr_q];
         valid_out_d = 1'b1;
      end

      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

`ifdef FIFO_ERR_STICKY_EN
      fifo_error_d = fifo_error_q || rejected;
`else
      fifo_error_d = rejected;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         data_out_q   <= '0;
         valid_out_q  <= 1'b0;
         fifo_error_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         data_out_q   <= data_out_d;
         valid_out_q  <= valid_out_d;
         fifo_error_q <= fifo_error_d;
      end
   end

   // Storage is left uncleared on reset; the pointers alone decide what is readable.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= bus.data_in;
      end
   end

   assign bus.data_out     = data_out_q;
   assign bus.valid_out    = valid_out_q;
   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (count_q >= bus.af_thresh);
   assign bus.almost_empty = (count_q <= bus.ae_thresh);
   assign bus.fifo_error   = fifo_error_q;

endmodule
